// File: rtl/gcd_engine.sv
// Subtractive GCD engine: IDLE -> LOAD -> CALC -> DONE, one subtraction per CALC cycle.
// Define GCD_ITER_CNT_EN to add the saturating iter_cnt output.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_err
`ifdef GCD_ITER_CNT_EN
   ,output logic [CNT_W-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             accept;
    logic             any_zero;

    assign accept   = (state == IDLE) && start;
    assign any_zero = (a_reg == '0) || (b_reg == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = any_zero ? DONE : CALC;
            CALC: if (a_reg == b_reg) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are only written on accept or by CALC, so a held start cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            result   <= '0;
            zero_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        zero_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (any_zero) begin
                        result   <= a_reg | b_reg;
                        zero_err <= (a_reg == '0) && (b_reg == '0);
                    end
                end
                CALC: begin
                    if (a_reg > b_reg) begin
                        a_reg <= a_reg - b_reg;
                    end else if (b_reg > a_reg) begin
                        b_reg <= b_reg - a_reg;
                    end else begin
                        result <= a_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    // Counts CALC subtraction cycles; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
        end else if ((state == CALC) && (a_reg != b_reg) && (iter_cnt != '1)) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: directed vectors push expectations, a negedge
// monitor pops one per done pulse and checks result, flags and latency.
module tb_gcd_engine;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int WAIT_LIMIT = 70000;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] result;
        logic             zero_err;
        longint           iter;
        int               done_cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero_err;
`ifdef GCD_ITER_CNT_EN
    logic [CNT_W-1:0] iter_cnt;
`endif

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   passed;
    int   fails;

    gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero_err (zero_err)
`ifdef GCD_ITER_CNT_EN
       ,.iter_cnt (iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] global timeout");
    end

    function automatic longint satIter(input longint n);
        longint top;
        top = (longint'(1) << CNT_W) - 1;
        return (n > top) ? top : n;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end else begin
            passed++;
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, result, e.result);
                checkOutput({e.name, "_zero_err"}, zero_err, e.zero_err);
                checkOutput({e.name, "_done_cycle"}, cyc, e.done_cyc);
`ifdef GCD_ITER_CNT_EN
                checkOutput({e.name, "_iter_cnt"}, iter_cnt, satIter(e.iter));
`endif
            end
        end
    end

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput({name, "_wait_idle"}, busy, 0);
    endtask

    // Issues one start pulse from IDLE; lat is edges from the accept edge to the done cycle.
    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int lat, input logic [WIDTH-1:0] exp_r, input logic exp_z,
                                 input longint exp_iter);
        exp_t e;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        e.name     = name;
        e.result   = exp_r;
        e.zero_err = exp_z;
        e.iter     = exp_iter;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        waitIdle(name);
    endtask

    initial begin
        exp_t e;
        int   n;
        cyc    = 0;
        checks = 0;
        passed = 0;
        fails  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_zero_err", zero_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("g48_18",  16'd48,    16'd18,    6,     16'd6,  1'b0, 4);
        applyStimulus("g12_12",  16'd12,    16'd12,    2,     16'd12, 1'b0, 0);
        applyStimulus("g0_35",   16'd0,     16'd35,    1,     16'd35, 1'b0, 0);
        applyStimulus("g0_0",    16'd0,     16'd0,     1,     16'd0,  1'b1, 0);
        applyStimulus("g7_5",    16'd7,     16'd5,     6,     16'd1,  1'b0, 4);
        applyStimulus("g35_0",   16'd35,    16'd0,     1,     16'd35, 1'b0, 0);
        applyStimulus("gmax_max", 16'hFFFF, 16'hFFFF,  2,     16'hFFFF, 1'b0, 0);
        applyStimulus("gmax_1",  16'hFFFF,  16'd1,     65536, 16'd1,  1'b0, 65534);

        // start held high through the whole run with new operands on the bus
        a_in  = 16'd48;
        b_in  = 16'd18;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in       = 16'd7;
        b_in       = 16'd7;
        e.name     = "hold_48_18";
        e.result   = 16'd6;
        e.zero_err = 1'b0;
        e.iter     = 4;
        e.done_cyc = cyc + 6;
        sb.push_back(e);
        n = 0;
        while (!done && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("hold_wait_done", done, 1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        e.name     = "hold_7_7";
        e.result   = 16'd7;
        e.zero_err = 1'b0;
        e.iter     = 0;
        e.done_cyc = cyc + 2;
        sb.push_back(e);
        waitIdle("hold_7_7");
        repeat (4) @(negedge clk);

        // reset in the second CALC cycle aborts silently
        a_in  = 16'd48;
        b_in  = 16'd18;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_zero_err", zero_err, 0);
`ifdef GCD_ITER_CNT_EN
        checkOutput("abort_iter_cnt", iter_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        applyStimulus("g21_14", 16'd21, 16'd14, 4, 16'd7, 1'b0, 2);

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
